// File: rtl/pipe_control.sv
// ID stage control for a 5-stage MIPS pipe: combinational decode, ID/EX control
// register, load-use stall detection and saturating stall/illegal event counters.
module pipe_control #(
  parameter int CNT_W     = 16,
  parameter int HAZARD_EN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [31:0]      instruction,
  output logic             in_ready,
  input  logic             flush,
  input  logic             ex_hold,
  output logic             ex_valid,
  output logic             ex_regdst,
  output logic             ex_branch,
  output logic             ex_memtoreg,
  output logic             ex_alusrc1,
  output logic             ex_alusrc2,
  output logic             ex_regwrite,
  output logic             ex_jump,
  output logic             ex_extop,
  output logic [1:0]       ex_memread,
  output logic [1:0]       ex_memwrite,
  output logic [4:0]       ex_aluctr,
  output logic [4:0]       ex_rs,
  output logic [4:0]       ex_rt,
  output logic [4:0]       ex_rd,
  output logic             stall,
  output logic             illegal,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] illegal_cnt
);

  typedef struct packed {
    logic       regdst;
    logic       branch;
    logic       memtoreg;
    logic       alusrc1;
    logic       alusrc2;
    logic       regwrite;
    logic       jump;
    logic       extop;
    logic [1:0] memread;
    logic [1:0] memwrite;
    logic [4:0] aluctr;
  } ctrl_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [5:0] op;
  logic [5:0] func;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic [4:0] id_rd;
  ctrl_t      dec;
  logic       dec_ok;
  logic       uses_rt;
  logic       hazard;
  ctrl_t      ex_ctrl;

  assign op    = instruction[31:26];
  assign func  = instruction[5:0];
  assign id_rs = instruction[25:21];
  assign id_rt = instruction[20:16];
  assign id_rd = instruction[15:11];

  always_comb begin
    dec     = '0;
    dec_ok  = 1'b0;
    uses_rt = 1'b0;
    case (op)
      6'b000000: begin
        dec_ok  = 1'b1;
        uses_rt = 1'b1;
        // The all-zero word is the canonical nop, not an sll that writes $0.
        if (instruction != 32'd0) begin
          dec.regdst   = 1'b1;
          dec.regwrite = 1'b1;
          dec.alusrc1  = (func == 6'b000000) || (func[5:1] == 5'b00001);
          dec.jump     = (func == 6'b001000);
          dec.aluctr   = {func[5], func[3:0]};
        end
      end
      6'b001000, 6'b001001, 6'b001010, 6'b001011,
      6'b001100, 6'b001101, 6'b001110, 6'b001111: begin
        dec_ok       = 1'b1;
        dec.alusrc2  = 1'b1;
        dec.regwrite = 1'b1;
        dec.extop    = (op[2] == 1'b0);
        case (op[2:0])
          3'b000:  dec.aluctr = 5'b10000;
          3'b001:  dec.aluctr = 5'b10001;
          3'b010:  dec.aluctr = 5'b11010;
          3'b011:  dec.aluctr = 5'b11011;
          3'b100:  dec.aluctr = 5'b10100;
          3'b101:  dec.aluctr = 5'b10101;
          3'b110:  dec.aluctr = 5'b10110;
          default: dec.aluctr = 5'b11000;
        endcase
      end
      6'b000100, 6'b000101: begin
        dec_ok     = 1'b1;
        uses_rt    = 1'b1;
        dec.branch = 1'b1;
        dec.aluctr = 5'b10011;
      end
      6'b000001, 6'b000110: begin
        dec_ok     = 1'b1;
        dec.branch = 1'b1;
      end
      6'b100000, 6'b100001, 6'b100011: begin
        dec_ok       = 1'b1;
        dec.memtoreg = 1'b1;
        dec.alusrc2  = 1'b1;
        dec.regwrite = 1'b1;
        dec.extop    = 1'b1;
        dec.aluctr   = 5'b10001;
        dec.memread  = (op[1:0] == 2'b00) ? 2'b01 : (op[1:0] == 2'b01) ? 2'b10 : 2'b11;
      end
      6'b101000, 6'b101001, 6'b101011: begin
        dec_ok       = 1'b1;
        uses_rt      = 1'b1;
        dec.alusrc2  = 1'b1;
        dec.extop    = 1'b1;
        dec.aluctr   = 5'b10001;
        dec.memwrite = (op[1:0] == 2'b00) ? 2'b01 : (op[1:0] == 2'b01) ? 2'b10 : 2'b11;
      end
      6'b000010, 6'b000011: begin
        dec_ok   = 1'b1;
        dec.jump = 1'b1;
      end
      default: begin
        dec_ok = 1'b0;
      end
    endcase
  end

  assign hazard = (HAZARD_EN != 0) && ex_valid && (ex_ctrl.memread != 2'b00) &&
                  (ex_rt != 5'd0) && in_valid &&
                  ((id_rs == ex_rt) || ((id_rt == ex_rt) && uses_rt));

  assign stall    = hazard && !flush && !ex_hold;
  assign in_ready = flush || (!ex_hold && !hazard);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid    <= 1'b0;
      ex_ctrl     <= '0;
      ex_rs       <= '0;
      ex_rt       <= '0;
      ex_rd       <= '0;
      illegal     <= 1'b0;
      stall_cnt   <= '0;
      illegal_cnt <= '0;
    end else if (flush || (!ex_hold && (hazard || !in_valid))) begin
      ex_valid <= 1'b0;
      ex_ctrl  <= '0;
      ex_rs    <= '0;
      ex_rt    <= '0;
      ex_rd    <= '0;
      if (!flush && hazard && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_ONE;
    end else if (!ex_hold) begin
      ex_valid <= 1'b1;
      ex_ctrl  <= dec;
      ex_rs    <= id_rs;
      ex_rt    <= id_rt;
      ex_rd    <= id_rd;
      if (!dec_ok) begin
        illegal <= 1'b1;
        if (illegal_cnt != '1) illegal_cnt <= illegal_cnt + CNT_ONE;
      end
    end
  end

  assign ex_regdst   = ex_ctrl.regdst;
  assign ex_branch   = ex_ctrl.branch;
  assign ex_memtoreg = ex_ctrl.memtoreg;
  assign ex_alusrc1  = ex_ctrl.alusrc1;
  assign ex_alusrc2  = ex_ctrl.alusrc2;
  assign ex_regwrite = ex_ctrl.regwrite;
  assign ex_jump     = ex_ctrl.jump;
  assign ex_extop    = ex_ctrl.extop;
  assign ex_memread  = ex_ctrl.memread;
  assign ex_memwrite = ex_ctrl.memwrite;
  assign ex_aluctr   = ex_ctrl.aluctr;

endmodule

// File: tb/tb_pipe_control.sv
// Directed bench for pipe_control: three instances (default, no hazard, 2-bit
// counters) share one stimulus stream; expected values are hand-computed.
module tb_pipe_control;

  localparam logic [31:0] I_ADDI = 32'h2008_0005;  // addi $8,$0,5
  localparam logic [31:0] I_LW   = 32'h8D28_0000;  // lw   $8,0($9)
  localparam logic [31:0] I_ADD  = 32'h010B_5020;  // add  $10,$8,$11
  localparam logic [31:0] I_SW   = 32'hAD28_0000;  // sw   $8,0($9)
  localparam logic [31:0] I_BAD  = 32'hFC00_0000;  // opcode 111111
  localparam logic [31:0] I_NOP  = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid;
  logic [31:0] instruction;
  logic flush;
  logic ex_hold;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic        in_ready;
    logic        ex_valid;
    logic        ex_regdst, ex_branch, ex_memtoreg, ex_alusrc1, ex_alusrc2;
    logic        ex_regwrite, ex_jump, ex_extop;
    logic [1:0]  ex_memread, ex_memwrite;
    logic [4:0]  ex_aluctr, ex_rs, ex_rt, ex_rd;
    logic        stall, illegal;
  } obs_t;

  obs_t a, n, s;
  logic [15:0] a_stall_cnt, a_illegal_cnt, n_stall_cnt, n_illegal_cnt;
  logic [1:0]  s_stall_cnt, s_illegal_cnt;

  always #5 clk = ~clk;

  pipe_control u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .instruction(instruction),
    .in_ready(a.in_ready), .flush(flush), .ex_hold(ex_hold), .ex_valid(a.ex_valid),
    .ex_regdst(a.ex_regdst), .ex_branch(a.ex_branch), .ex_memtoreg(a.ex_memtoreg),
    .ex_alusrc1(a.ex_alusrc1), .ex_alusrc2(a.ex_alusrc2), .ex_regwrite(a.ex_regwrite),
    .ex_jump(a.ex_jump), .ex_extop(a.ex_extop), .ex_memread(a.ex_memread),
    .ex_memwrite(a.ex_memwrite), .ex_aluctr(a.ex_aluctr), .ex_rs(a.ex_rs),
    .ex_rt(a.ex_rt), .ex_rd(a.ex_rd), .stall(a.stall), .illegal(a.illegal),
    .stall_cnt(a_stall_cnt), .illegal_cnt(a_illegal_cnt)
  );

  pipe_control #(.CNT_W(16), .HAZARD_EN(0)) u_dut_nh (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .instruction(instruction),
    .in_ready(n.in_ready), .flush(flush), .ex_hold(ex_hold), .ex_valid(n.ex_valid),
    .ex_regdst(n.ex_regdst), .ex_branch(n.ex_branch), .ex_memtoreg(n.ex_memtoreg),
    .ex_alusrc1(n.ex_alusrc1), .ex_alusrc2(n.ex_alusrc2), .ex_regwrite(n.ex_regwrite),
    .ex_jump(n.ex_jump), .ex_extop(n.ex_extop), .ex_memread(n.ex_memread),
    .ex_memwrite(n.ex_memwrite), .ex_aluctr(n.ex_aluctr), .ex_rs(n.ex_rs),
    .ex_rt(n.ex_rt), .ex_rd(n.ex_rd), .stall(n.stall), .illegal(n.illegal),
    .stall_cnt(n_stall_cnt), .illegal_cnt(n_illegal_cnt)
  );

  pipe_control #(.CNT_W(2), .HAZARD_EN(1)) u_dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .instruction(instruction),
    .in_ready(s.in_ready), .flush(flush), .ex_hold(ex_hold), .ex_valid(s.ex_valid),
    .ex_regdst(s.ex_regdst), .ex_branch(s.ex_branch), .ex_memtoreg(s.ex_memtoreg),
    .ex_alusrc1(s.ex_alusrc1), .ex_alusrc2(s.ex_alusrc2), .ex_regwrite(s.ex_regwrite),
    .ex_jump(s.ex_jump), .ex_extop(s.ex_extop), .ex_memread(s.ex_memread),
    .ex_memwrite(s.ex_memwrite), .ex_aluctr(s.ex_aluctr), .ex_rs(s.ex_rs),
    .ex_rt(s.ex_rt), .ex_rd(s.ex_rd), .stall(s.stall), .illegal(s.illegal),
    .stall_cnt(s_stall_cnt), .illegal_cnt(s_illegal_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic f, input logic h);
    in_valid    = v;
    instruction = ins;
    flush       = f;
    ex_hold     = h;
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, I_NOP, 1'b0, 1'b0);
    #2;
    chk("rst_ex_valid", {31'd0, a.ex_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, a.in_ready}, 32'd1);
    chk("rst_stall_cnt", {16'd0, a_stall_cnt}, 32'd0);
    chk("rst_illegal", {31'd0, a.illegal}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // addi: decoded controls appear one cycle after acceptance
    drive(1'b1, I_ADDI, 1'b0, 1'b0);
    chk("addi_in_ready", {31'd0, a.in_ready}, 32'd1);
    chk("addi_stall", {31'd0, a.stall}, 32'd0);
    tick();
    chk("addi_ex_valid", {31'd0, a.ex_valid}, 32'd1);
    chk("addi_alusrc2", {31'd0, a.ex_alusrc2}, 32'd1);
    chk("addi_regwrite", {31'd0, a.ex_regwrite}, 32'd1);
    chk("addi_extop", {31'd0, a.ex_extop}, 32'd1);
    chk("addi_aluctr", {27'd0, a.ex_aluctr}, 32'h10);
    chk("addi_rt", {27'd0, a.ex_rt}, 32'd8);
    chk("addi_regdst", {31'd0, a.ex_regdst}, 32'd0);
    chk("addi_memread", {30'd0, a.ex_memread}, 32'd0);

    // lw then dependent add
    drive(1'b1, I_LW, 1'b0, 1'b0);
    tick();
    chk("lw_memread", {30'd0, a.ex_memread}, 32'd3);
    chk("lw_memtoreg", {31'd0, a.ex_memtoreg}, 32'd1);
    chk("lw_aluctr", {27'd0, a.ex_aluctr}, 32'h11);
    drive(1'b1, I_ADD, 1'b0, 1'b0);
    chk("lu_stall", {31'd0, a.stall}, 32'd1);
    chk("lu_in_ready", {31'd0, a.in_ready}, 32'd0);
    chk("nh_stall", {31'd0, n.stall}, 32'd0);
    chk("nh_in_ready", {31'd0, n.in_ready}, 32'd1);
    tick();
    chk("lu_bubble", {31'd0, a.ex_valid}, 32'd0);
    chk("lu_stall_cnt", {16'd0, a_stall_cnt}, 32'd1);
    chk("nh_add_valid", {31'd0, n.ex_valid}, 32'd1);
    chk("nh_add_rd", {27'd0, n.ex_rd}, 32'd10);
    chk("nh_stall_cnt", {16'd0, n_stall_cnt}, 32'd0);
    chk("lu_stall_clear", {31'd0, a.stall}, 32'd0);
    tick();
    chk("add_ex_valid", {31'd0, a.ex_valid}, 32'd1);
    chk("add_rd", {27'd0, a.ex_rd}, 32'd10);
    chk("add_regdst", {31'd0, a.ex_regdst}, 32'd1);
    chk("add_aluctr", {27'd0, a.ex_aluctr}, 32'h10);
    chk("add_alusrc1", {31'd0, a.ex_alusrc1}, 32'd0);

    // flush wins over hold
    drive(1'b1, I_SW, 1'b1, 1'b1);
    chk("flush_in_ready", {31'd0, a.in_ready}, 32'd1);
    chk("flush_stall", {31'd0, a.stall}, 32'd0);
    tick();
    chk("flush_ex_valid", {31'd0, a.ex_valid}, 32'd0);
    chk("flush_memwrite", {30'd0, a.ex_memwrite}, 32'd0);

    // hold keeps ID/EX contents
    drive(1'b1, I_SW, 1'b0, 1'b0);
    tick();
    chk("sw_memwrite", {30'd0, a.ex_memwrite}, 32'd3);
    drive(1'b1, I_ADDI, 1'b0, 1'b1);
    chk("hold_in_ready", {31'd0, a.in_ready}, 32'd0);
    tick();
    chk("hold_ex_valid", {31'd0, a.ex_valid}, 32'd1);
    chk("hold_memwrite", {30'd0, a.ex_memwrite}, 32'd3);
    chk("hold_rs", {27'd0, a.ex_rs}, 32'd9);
    chk("hold_alusrc2", {31'd0, a.ex_alusrc2}, 32'd1);

    // unsupported opcode, then nop
    drive(1'b1, I_BAD, 1'b0, 1'b0);
    tick();
    chk("ill_flag", {31'd0, a.illegal}, 32'd1);
    chk("ill_cnt", {16'd0, a_illegal_cnt}, 32'd1);
    chk("ill_regwrite", {31'd0, a.ex_regwrite}, 32'd0);
    chk("ill_alusrc2", {31'd0, a.ex_alusrc2}, 32'd0);
    chk("ill_aluctr", {27'd0, a.ex_aluctr}, 32'd0);
    drive(1'b1, I_NOP, 1'b0, 1'b0);
    tick();
    chk("nop_valid", {31'd0, a.ex_valid}, 32'd1);
    chk("nop_regdst", {31'd0, a.ex_regdst}, 32'd0);
    chk("nop_regwrite", {31'd0, a.ex_regwrite}, 32'd0);
    chk("nop_alusrc1", {31'd0, a.ex_alusrc1}, 32'd0);
    chk("ill_sticky", {31'd0, a.illegal}, 32'd1);
    chk("ill_cnt_nop", {16'd0, a_illegal_cnt}, 32'd1);

    // illegal counter saturation on the 2-bit instance
    drive(1'b1, I_BAD, 1'b0, 1'b0);
    tick();
    tick();
    chk("sat_ill_at_max", {30'd0, s_illegal_cnt}, 32'd3);
    tick();
    chk("sat_ill_hold", {30'd0, s_illegal_cnt}, 32'd3);
    chk("wide_ill_cnt", {16'd0, a_illegal_cnt}, 32'd4);

    // three more load-use stalls: 2-bit stall counter pins at 3
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, I_LW, 1'b0, 1'b0);
      tick();
      drive(1'b1, I_ADD, 1'b0, 1'b0);
      tick();
      tick();
    end
    chk("sat_stall_cnt", {30'd0, s_stall_cnt}, 32'd3);
    chk("wide_stall_cnt", {16'd0, a_stall_cnt}, 32'd4);

    // async reset mid-stall, no replay
    drive(1'b1, I_LW, 1'b0, 1'b0);
    tick();
    drive(1'b1, I_ADD, 1'b0, 1'b0);
    chk("pre_rst_valid", {31'd0, a.ex_valid}, 32'd1);
    chk("pre_rst_stall", {31'd0, a.stall}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_ex_valid", {31'd0, a.ex_valid}, 32'd0);
    chk("arst_stall_cnt", {16'd0, a_stall_cnt}, 32'd0);
    chk("arst_illegal_cnt", {16'd0, a_illegal_cnt}, 32'd0);
    chk("arst_illegal", {31'd0, a.illegal}, 32'd0);
    chk("arst_memread", {30'd0, a.ex_memread}, 32'd0);
    chk("arst_stall", {31'd0, a.stall}, 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("no_replay", {31'd0, a.ex_valid}, 32'd0);
    chk("no_replay_rd", {27'd0, a.ex_rd}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
